// File: rtl/walk_req_bank_pkg.sv
// Shared traffic package: channel-index width helper and the offer FSM state encoding.
package walk_req_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } offerState_t;

  // Width of a channel index; never below one bit so a port is always declarable.
  function automatic int chIdxWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/walk_req_chan.sv
// One pedestrian channel: saturating debounce counter feeding a set-dominant request latch.
module walk_req_chan #(
  parameter int DEB_CYCLES = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Sync_WalkReq,
  input  logic WalkReg_Reset,
  input  logic Ack_Clr,
  output logic WalkReq
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] debCnt_reg;
  logic             setEvt;

  // Saturation at CNT_MAX means a held button can only pass CNT_ARM once.
  assign setEvt = Sync_WalkReq && (debCnt_reg == CNT_ARM);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      debCnt_reg <= '0;
    end else if (!Sync_WalkReq) begin
      debCnt_reg <= '0;
    end else if (debCnt_reg != CNT_MAX) begin
      debCnt_reg <= debCnt_reg + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      WalkReq <= 1'b0;
    end else if (setEvt) begin
      WalkReq <= 1'b1;
    end else if (WalkReg_Reset || Ack_Clr) begin
      WalkReq <= 1'b0;
    end
  end

endmodule

// File: rtl/walk_req_bank.sv
// Bank of debounced pedestrian requests with a round-robin offer FSM towards the signal controller.
module walk_req_bank
  import walk_req_bank_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DEB_CYCLES = 3
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic [NUM_CH-1:0]               Sync_WalkReq,
  input  logic [NUM_CH-1:0]               WalkReg_Reset,
  input  logic                            Req_Ack,
  output logic [NUM_CH-1:0]               WalkReq,
  output logic                            Req_Valid,
  output logic [chIdxWidth(NUM_CH)-1:0]   Req_Ch,
  output logic [$clog2(NUM_CH+1)-1:0]     Pending_Cnt
);

  localparam int CH_W = chIdxWidth(NUM_CH);
  localparam int PC_W = $clog2(NUM_CH + 1);

  offerState_t       state_reg;
  logic [CH_W-1:0]   rrPtr_reg;
  logic [CH_W-1:0]   pickCh;
  logic [CH_W-1:0]   nextPtr;
  logic [CH_W-1:0]   scanIdx;
  logic              anyPending;
  logic              found;
  logic [NUM_CH-1:0] ackClr;
  int                scanPos;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign ackClr[gi] = Req_Ack && Req_Valid && (Req_Ch == CH_W'(gi));

      walk_req_chan #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_chan (
        .Clk          (Clk),
        .Reset        (Reset),
        .Sync_WalkReq (Sync_WalkReq[gi]),
        .WalkReg_Reset(WalkReg_Reset[gi]),
        .Ack_Clr      (ackClr[gi]),
        .WalkReq      (WalkReq[gi])
      );
    end
  endgenerate

  // Upward search from rrPtr_reg with wrap; the first hit wins.
  always_comb begin
    pickCh     = '0;
    found      = 1'b0;
    scanPos    = 0;
    scanIdx    = '0;
    anyPending = |WalkReq;
    for (int k = 0; k < NUM_CH; k++) begin
      scanPos = int'(rrPtr_reg) + k;
      if (scanPos >= NUM_CH) begin
        scanPos = scanPos - NUM_CH;
      end
      scanIdx = CH_W'(scanPos);
      if (!found && WalkReq[scanIdx]) begin
        found  = 1'b1;
        pickCh = scanIdx;
      end
    end
  end

  assign nextPtr = (Req_Ch == CH_W'(NUM_CH - 1)) ? '0 : Req_Ch + 1'b1;

  always_comb begin
    Pending_Cnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      Pending_Cnt = Pending_Cnt + PC_W'(WalkReq[k]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      rrPtr_reg <= '0;
      Req_Valid <= 1'b0;
      Req_Ch    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (anyPending) begin
            Req_Ch    <= pickCh;
            Req_Valid <= 1'b1;
            state_reg <= OFFER;
          end
        end
        OFFER: begin
          // Offer stays frozen until the controller takes it or the channel is cleared.
          if (Req_Ack) begin
            rrPtr_reg <= nextPtr;
            Req_Valid <= 1'b0;
            state_reg <= IDLE;
          end else if (WalkReg_Reset[Req_Ch]) begin
            Req_Valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          Req_Valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_walk_req_bank.sv
// Directed bench for walk_req_bank (NUM_CH=4, DEB_CYCLES=3); each check compares {WalkReq, Req_Valid, Req_Ch, Pending_Cnt}.
module tb_walk_req_bank;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Sync_WalkReq = '0;
  logic [3:0] WalkReg_Reset = '0;
  logic       Req_Ack = 1'b0;
  logic [3:0] WalkReq;
  logic       Req_Valid;
  logic [1:0] Req_Ch;
  logic [2:0] Pending_Cnt;
  logic [9:0] st;
  int         total = 0;
  int         bad = 0;

  walk_req_bank #(.NUM_CH(4), .DEB_CYCLES(3)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Sync_WalkReq (Sync_WalkReq),
    .WalkReg_Reset(WalkReg_Reset),
    .Req_Ack      (Req_Ack),
    .WalkReq      (WalkReq),
    .Req_Valid    (Req_Valid),
    .Req_Ch       (Req_Ch),
    .Pending_Cnt  (Pending_Cnt)
  );

  always #5 Clk = ~Clk;

  assign st = {WalkReq, Req_Valid, Req_Ch, Pending_Cnt};

  function automatic logic [9:0] ex(input logic [3:0] w, input logic v, input logic [1:0] c);
    logic [2:0] n;
    n = 3'($countones(w));
    return {w, v, c, n};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(2);
    total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL reset_state: got %b want %b", st, ex(4'b0000, 1'b0, 2'd0)); end
    Reset = 1'b0;
    tick();
    total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL reset_idle: got %b want %b", st, ex(4'b0000, 1'b0, 2'd0)); end
  endtask

  task automatic test_short_pulse();
    Sync_WalkReq = 4'b0100;
    tick(2);
    total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL short_pulse_hi: got %b want %b", st, ex(4'b0000, 1'b0, 2'd0)); end
    Sync_WalkReq = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL short_pulse_lo%0d: got %b want %b", i, st, ex(4'b0000, 1'b0, 2'd0)); end
    end
  endtask

  task automatic test_single_press();
    Sync_WalkReq = 4'b0010;
    tick(2);
    total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL press_2nd_edge: got %b want %b", st, ex(4'b0000, 1'b0, 2'd0)); end
    tick();
    total++; if (st !== ex(4'b0010, 1'b0, 2'd0)) begin bad++; $display("FAIL press_3rd_edge: got %b want %b", st, ex(4'b0010, 1'b0, 2'd0)); end
    tick();
    total++; if (st !== ex(4'b0010, 1'b1, 2'd1)) begin bad++; $display("FAIL press_offer: got %b want %b", st, ex(4'b0010, 1'b1, 2'd1)); end
    Req_Ack = 1'b1;
    tick();
    total++; if (st !== ex(4'b0000, 1'b0, 2'd1)) begin bad++; $display("FAIL press_ack: got %b want %b", st, ex(4'b0000, 1'b0, 2'd1)); end
    Req_Ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (st !== ex(4'b0000, 1'b0, 2'd1)) begin bad++; $display("FAIL press_held%0d: got %b want %b", i, st, ex(4'b0000, 1'b0, 2'd1)); end
    end
    Sync_WalkReq = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Sync_WalkReq = 4'b1001;
    tick(3);
    total++; if (st !== ex(4'b1001, 1'b0, 2'd0)) begin bad++; $display("FAIL rr_pending: got %b want %b", st, ex(4'b1001, 1'b0, 2'd0)); end
    Sync_WalkReq = 4'b0000;
    tick();
    total++; if (st !== ex(4'b1001, 1'b1, 2'd0)) begin bad++; $display("FAIL rr_offer0: got %b want %b", st, ex(4'b1001, 1'b1, 2'd0)); end
    Req_Ack = 1'b1;
    tick();
    total++; if (st !== ex(4'b1000, 1'b0, 2'd0)) begin bad++; $display("FAIL rr_ack0: got %b want %b", st, ex(4'b1000, 1'b0, 2'd0)); end
    Req_Ack = 1'b0;
    tick();
    total++; if (st !== ex(4'b1000, 1'b1, 2'd3)) begin bad++; $display("FAIL rr_offer3: got %b want %b", st, ex(4'b1000, 1'b1, 2'd3)); end
    Sync_WalkReq = 4'b0001;
    tick(2);
    total++; if (st !== ex(4'b1000, 1'b1, 2'd3)) begin bad++; $display("FAIL rr_hold3a: got %b want %b", st, ex(4'b1000, 1'b1, 2'd3)); end
    tick();
    total++; if (st !== ex(4'b1001, 1'b1, 2'd3)) begin bad++; $display("FAIL rr_hold3b: got %b want %b", st, ex(4'b1001, 1'b1, 2'd3)); end
    Sync_WalkReq = 4'b0000;
    Req_Ack = 1'b1;
    tick();
    total++; if (st !== ex(4'b0001, 1'b0, 2'd3)) begin bad++; $display("FAIL rr_ack3: got %b want %b", st, ex(4'b0001, 1'b0, 2'd3)); end
    Req_Ack = 1'b0;
    tick();
    total++; if (st !== ex(4'b0001, 1'b1, 2'd0)) begin bad++; $display("FAIL rr_wrap0: got %b want %b", st, ex(4'b0001, 1'b1, 2'd0)); end
    Req_Ack = 1'b1;
    tick();
    Req_Ack = 1'b0;
    total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL rr_drain: got %b want %b", st, ex(4'b0000, 1'b0, 2'd0)); end
  endtask

  task automatic test_set_wins();
    Sync_WalkReq = 4'b0010;
    tick(3);
    Sync_WalkReq = 4'b0000;
    tick();
    total++; if (st !== ex(4'b0010, 1'b1, 2'd1)) begin bad++; $display("FAIL setwin_offer: got %b want %b", st, ex(4'b0010, 1'b1, 2'd1)); end
    Sync_WalkReq = 4'b0010;
    tick(2);
    Req_Ack = 1'b1;
    tick();
    total++; if (st !== ex(4'b0010, 1'b0, 2'd1)) begin bad++; $display("FAIL setwin_collide: got %b want %b", st, ex(4'b0010, 1'b0, 2'd1)); end
    Req_Ack = 1'b0;
    Sync_WalkReq = 4'b0000;
    tick();
    total++; if (st !== ex(4'b0010, 1'b1, 2'd1)) begin bad++; $display("FAIL setwin_reoffer: got %b want %b", st, ex(4'b0010, 1'b1, 2'd1)); end
    Req_Ack = 1'b1;
    tick();
    Req_Ack = 1'b0;
    total++; if (st !== ex(4'b0000, 1'b0, 2'd1)) begin bad++; $display("FAIL setwin_drain: got %b want %b", st, ex(4'b0000, 1'b0, 2'd1)); end
  endtask

  task automatic test_withdraw();
    Sync_WalkReq = 4'b1100;
    tick(3);
    Sync_WalkReq = 4'b0000;
    tick();
    total++; if (st !== ex(4'b1100, 1'b1, 2'd2)) begin bad++; $display("FAIL wd_offer2: got %b want %b", st, ex(4'b1100, 1'b1, 2'd2)); end
    Sync_WalkReq = 4'b0100;
    tick(2);
    WalkReg_Reset = 4'b0100;
    tick();
    total++; if (st !== ex(4'b1100, 1'b0, 2'd2)) begin bad++; $display("FAIL wd_withdraw: got %b want %b", st, ex(4'b1100, 1'b0, 2'd2)); end
    WalkReg_Reset = 4'b0000;
    Sync_WalkReq = 4'b0000;
    tick();
    total++; if (st !== ex(4'b1100, 1'b1, 2'd2)) begin bad++; $display("FAIL wd_ptr_kept: got %b want %b", st, ex(4'b1100, 1'b1, 2'd2)); end
    Req_Ack = 1'b1;
    tick();
    total++; if (st !== ex(4'b1000, 1'b0, 2'd2)) begin bad++; $display("FAIL wd_ack2: got %b want %b", st, ex(4'b1000, 1'b0, 2'd2)); end
    tick();
    Req_Ack = 1'b0;
    total++; if (st !== ex(4'b1000, 1'b1, 2'd3)) begin bad++; $display("FAIL wd_ack_idle: got %b want %b", st, ex(4'b1000, 1'b1, 2'd3)); end
    WalkReg_Reset = 4'b1000;
    tick();
    WalkReg_Reset = 4'b0000;
    total++; if (st !== ex(4'b0000, 1'b0, 2'd3)) begin bad++; $display("FAIL wd_clear3: got %b want %b", st, ex(4'b0000, 1'b0, 2'd3)); end
    Req_Ack = 1'b1;
    tick();
    Req_Ack = 1'b0;
    total++; if (st !== ex(4'b0000, 1'b0, 2'd3)) begin bad++; $display("FAIL wd_stray_ack: got %b want %b", st, ex(4'b0000, 1'b0, 2'd3)); end
  endtask

  task automatic test_reset_in_offer();
    Sync_WalkReq = 4'b1111;
    tick(3);
    total++; if (st !== ex(4'b1111, 1'b0, 2'd3)) begin bad++; $display("FAIL rst_all_pending: got %b want %b", st, ex(4'b1111, 1'b0, 2'd3)); end
    Sync_WalkReq = 4'b0000;
    tick();
    total++; if (st !== ex(4'b1111, 1'b1, 2'd3)) begin bad++; $display("FAIL rst_offer3: got %b want %b", st, ex(4'b1111, 1'b1, 2'd3)); end
    Reset = 1'b1;
    Req_Ack = 1'b1;
    tick();
    total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL rst_in_offer: got %b want %b", st, ex(4'b0000, 1'b0, 2'd0)); end
    Reset = 1'b0;
    Req_Ack = 1'b0;
    tick();
    total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL rst_after: got %b want %b", st, ex(4'b0000, 1'b0, 2'd0)); end
  endtask

  task automatic test_reset_held_button();
    Reset = 1'b1;
    Sync_WalkReq = 4'b0010;
    tick(2);
    total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL held_in_reset: got %b want %b", st, ex(4'b0000, 1'b0, 2'd0)); end
    Reset = 1'b0;
    tick(2);
    total++; if (st !== ex(4'b0000, 1'b0, 2'd0)) begin bad++; $display("FAIL held_2nd_edge: got %b want %b", st, ex(4'b0000, 1'b0, 2'd0)); end
    tick();
    total++; if (st !== ex(4'b0010, 1'b0, 2'd0)) begin bad++; $display("FAIL held_accept: got %b want %b", st, ex(4'b0010, 1'b0, 2'd0)); end
    Sync_WalkReq = 4'b0000;
    tick();
    total++; if (st !== ex(4'b0010, 1'b1, 2'd1)) begin bad++; $display("FAIL held_offer: got %b want %b", st, ex(4'b0010, 1'b1, 2'd1)); end
  endtask

  initial begin
    test_reset();
    test_short_pulse();
    test_single_press();
    test_round_robin();
    test_set_wins();
    test_withdraw();
    test_reset_in_offer();
    test_reset_held_button();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
